// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode a MIPS instruction into a registered valid/ready ALU command
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        illegal,
  output logic [15:0] issue_cnt
);
  typedef enum logic [3:0] {
    ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
    NOR = 4'd5, SRL = 4'd6, SLL = 4'd7, ADDU = 4'd8, SUBU = 4'd9
  } alu_op_e;
  logic [5:0]  opc, fn;
  logic [31:0] sx, zx, sh;
  alu_op_e     d_op;
  logic [31:0] d_in1, d_in2;
  logic [4:0]  d_dest;
  logic        d_wb, d_ill, d_rw, unused_rs;
  assign opc = instr[31:26];
  assign fn = instr[5:0];
  assign sx = {{16{instr[15]}}, instr[15:0]};
  assign zx = {16'b0, instr[15:0]};
  assign sh = {27'b0, instr[10:6]};
  assign unused_rs = ^instr[25:21];
  assign in_ready = !out_valid || out_ready;
  always_comb begin
    d_op = ADDU;
    d_in1 = '0;
    d_in2 = '0;
    d_dest = '0;
    d_wb = 1'b1;
    d_ill = 1'b0;
    if (opc == 6'h00) begin
      d_dest = instr[15:11];
      d_in1 = rs_data;
      d_in2 = rt_data;
      case (fn)
        6'h20: d_op = ADD;
        6'h21: d_op = ADDU;
        6'h22: d_op = SUB;
        6'h23: d_op = SUBU;
        6'h24: d_op = AND;
        6'h25: d_op = OR;
        6'h26: d_op = XOR;
        6'h27: d_op = NOR;
        6'h00: begin d_op = SLL; d_in1 = rt_data; d_in2 = sh; end
        6'h02: begin d_op = SRL; d_in1 = rt_data; d_in2 = sh; end
        default: d_ill = 1'b1;
      endcase
    end else begin
      d_dest = instr[20:16];
      d_in1 = rs_data;
      d_in2 = sx;
      case (opc)
        6'h08: d_op = ADD;
        6'h09, 6'h23: d_op = ADDU;
        6'h0C: begin d_op = AND; d_in2 = zx; end
        6'h0D: begin d_op = OR; d_in2 = zx; end
        6'h0E: begin d_op = XOR; d_in2 = zx; end
        6'h2B: d_wb = 1'b0;
        6'h04, 6'h05: begin d_op = SUBU; d_in2 = rt_data; d_wb = 1'b0; end
        default: d_ill = 1'b1;
      endcase
    end
    // illegal instructions still issue, but as a harmless ADDU 0,0 with no writeback
    if (d_ill) begin
      d_op = ADDU;
      d_in1 = '0;
      d_in2 = '0;
      d_dest = '0;
      d_wb = 1'b0;
    end
    d_rw = d_wb && d_dest != 5'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_op <= '0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      dest <= '0;
      reg_write <= 1'b0;
      illegal <= 1'b0;
      issue_cnt <= '0;
    end else begin
      if (flush) out_valid <= 1'b0;
      else if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        alu_op <= d_op;
        alu_in1 <= d_in1;
        alu_in2 <= d_in2;
        dest <= d_dest;
        reg_write <= d_rw;
        illegal <= d_ill;
      end else if (out_ready) out_valid <= 1'b0;
      if (out_valid && out_ready && !flush) issue_cnt <= issue_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plus randomized checks against a table-driven reference model
module tb_alu_issue_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0, alu_in1, alu_in2;
  logic [3:0] alu_op;
  logic [4:0] dest;
  logic reg_write, illegal;
  logic [15:0] issue_cnt;
  int vectors = 0, errors = 0;
  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .dest(dest), .reg_write(reg_write), .illegal(illegal), .issue_cnt(issue_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] op;
    logic [31:0] in1, in2;
    logic [4:0] dest;
    logic rw, ill;
  } cmd_t;
  int r_op[int];
  int i_op[int];
  logic [5:0] opcs [12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05};
  logic [5:0] fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02};
  logic m_v = 1'b0;
  cmd_t m_cmd = '0;
  logic [15:0] m_cnt = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic cmd_t ref_decode(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    cmd_t r;
    int opc = int'(i[31:26]);
    int fn = int'(i[5:0]);
    logic shift;
    r = '0;
    r.op = 4'd8;
    r.ill = 1'b1;
    if (opc == 0 && r_op.exists(fn)) begin
      shift = (fn == 'h00 || fn == 'h02);
      r.ill = 1'b0;
      r.op = 4'(r_op[fn]);
      r.in1 = shift ? b : a;
      r.in2 = shift ? 32'(i[10:6]) : b;
      r.dest = i[15:11];
      r.rw = r.dest != 0;
    end else if (opc != 0 && i_op.exists(opc)) begin
      r.ill = 1'b0;
      r.op = 4'(i_op[opc]);
      r.in1 = a;
      r.dest = i[20:16];
      if (opc >= 'h0C && opc <= 'h0E) r.in2 = 32'(i[15:0]);
      else if (opc == 'h04 || opc == 'h05) r.in2 = b;
      else r.in2 = 32'($signed(i[15:0]));
      r.rw = !(opc == 'h2B || opc == 'h04 || opc == 'h05) && r.dest != 0;
    end
    return r;
  endfunction
  task automatic check_out(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_v));
    chk({tag, ".cnt"}, 32'(issue_cnt), 32'(m_cnt));
    if (m_v) begin
      chk({tag, ".op"}, 32'(alu_op), 32'(m_cmd.op));
      chk({tag, ".in1"}, alu_in1, m_cmd.in1);
      chk({tag, ".in2"}, alu_in2, m_cmd.in2);
      chk({tag, ".dest"}, 32'(dest), 32'(m_cmd.dest));
      chk({tag, ".rw"}, 32'(reg_write), 32'(m_cmd.rw));
      chk({tag, ".ill"}, 32'(illegal), 32'(m_cmd.ill));
    end
  endtask
  task automatic step(input string tag, input logic v, input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] b, input logic f, input logic r);
    logic rdy;
    in_valid = v; instr = i; rs_data = a; rt_data = b; flush = f; out_ready = r;
    #1;
    rdy = !m_v || r;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    if (f) m_v = 1'b0;
    else begin
      if (m_v && r) m_cnt++;
      if (v && rdy) begin
        m_v = 1'b1;
        m_cmd = ref_decode(i, a, b);
      end else if (r) m_v = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_out(tag);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 0);
    chk({tag, ".op"}, 32'(alu_op), 0);
    chk({tag, ".in1"}, alu_in1, 0);
    chk({tag, ".in2"}, alu_in2, 0);
    chk({tag, ".dest"}, 32'(dest), 0);
    chk({tag, ".rw"}, 32'(reg_write), 0);
    chk({tag, ".ill"}, 32'(illegal), 0);
    chk({tag, ".cnt"}, 32'(issue_cnt), 0);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 12);
    if (k < 12) w[31:26] = opcs[k];
    if (w[31:26] == 6'h00 && $urandom_range(0, 9) != 0) w[5:0] = fns[$urandom_range(0, 9)];
    return w;
  endfunction
  initial begin
    logic [15:0] c0;
    r_op['h20] = 0; r_op['h21] = 8; r_op['h22] = 1; r_op['h23] = 9; r_op['h24] = 2;
    r_op['h25] = 3; r_op['h26] = 4; r_op['h27] = 5; r_op['h00] = 7; r_op['h02] = 6;
    i_op['h08] = 0; i_op['h09] = 8; i_op['h0C] = 2; i_op['h0D] = 3; i_op['h0E] = 4;
    i_op['h23] = 8; i_op['h2B] = 8; i_op['h04] = 9; i_op['h05] = 9;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    #1 chk("reset.in_ready", 32'(in_ready), 1);
    step("add", 1'b1, 32'h00221820, 32'd5, 32'd1, 1'b0, 1'b1);
    chk("add.op_k", 32'(alu_op), 0); chk("add.in1_k", alu_in1, 5); chk("add.in2_k", alu_in2, 1);
    chk("add.dest_k", 32'(dest), 3); chk("add.rw_k", 32'(reg_write), 1);
    step("addi", 1'b1, 32'h2022FFFF, 32'd7, 32'd9, 1'b0, 1'b1);
    chk("addi.in2_k", alu_in2, 32'hFFFFFFFF);
    step("ori", 1'b1, 32'h34228000, 32'd7, 32'd9, 1'b0, 1'b1);
    chk("ori.op_k", 32'(alu_op), 3); chk("ori.in2_k", alu_in2, 32'h00008000); chk("ori.dest_k", 32'(dest), 2);
    step("sll", 1'b1, 32'h000220C0, 32'h55, 32'h1, 1'b0, 1'b1);
    chk("sll.op_k", 32'(alu_op), 7); chk("sll.in1_k", alu_in1, 1); chk("sll.in2_k", alu_in2, 3);
    chk("sll.dest_k", 32'(dest), 4);
    step("bp_load", 1'b1, 32'h01095022, 32'd100, 32'd30, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step("bp_hold", 1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0);
    c0 = m_cnt;
    for (int k = 0; k < 4; k++) step("b2b", 1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b1);
    chk("b2b.cnt4", 32'(issue_cnt), 32'(c0 + 16'd4));
    step("fl_load", 1'b1, 32'h8C430010, 32'd8, 32'd0, 1'b0, 1'b0);
    c0 = m_cnt;
    step("flush", 1'b1, 32'h00221820, 32'd1, 32'd2, 1'b1, 1'b1);
    chk("flush.nocnt", 32'(issue_cnt), 32'(c0));
    step("illegal", 1'b1, 32'hFC000000, 32'd3, 32'd4, 1'b0, 1'b1);
    chk("illegal.ill_k", 32'(illegal), 1); chk("illegal.op_k", 32'(alu_op), 8);
    chk("illegal.rw_k", 32'(reg_write), 0);
    for (int k = 0; k < 400; k++)
      step("rand", $urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    step("stall_load", 1'b1, 32'h00A63825, 32'd11, 32'd12, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    m_v = 1'b0; m_cmd = '0; m_cnt = '0;
    #1 chk("post_rst.in_ready", 32'(in_ready), 1);
    step("post_rst", 1'b1, 32'h3C00FFFF, 32'd1, 32'd2, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
